// File: rtl/multi_line_shift_ram_if.sv
// Streaming port bundle for multi_line_shift_ram: sample input, clear/length load,
// and the parallel tap outputs with their strobes.
interface multi_line_shift_ram_if #(
  parameter int INPUT_WIDTH = 8,
  parameter int TAP_NUM     = 2,
  parameter int ADDR_WIDTH  = 16
);
  logic                           clken;
  logic                           sync_clr;
  logic [ADDR_WIDTH-1:0]          line_len;
  logic [INPUT_WIDTH-1:0]         shiftin;
  logic [TAP_NUM*INPUT_WIDTH-1:0] shiftout;
  logic                           shiftout_en;
  logic                           taps_valid;

  modport master (
    output clken, sync_clr, line_len, shiftin,
    input  shiftout, shiftout_en, taps_valid
  );

  modport slave (
    input  clken, sync_clr, line_len, shiftin,
    output shiftout, shiftout_en, taps_valid
  );
endinterface

// File: rtl/multi_line_shift_ram.sv
// Cascaded line delays with parallel taps; fill counting hides stale RAM contents.
// Optional extra output register stage: define MULTI_LINE_SHIFT_RAM_OUTREG_EN.
module multi_line_shift_ram #(
  parameter int INPUT_WIDTH = 8,
  parameter int MAX_LENGTH  = 640,
  parameter int TAP_NUM     = 2,
  parameter int ADDR_WIDTH  = 16
) (
  input logic                   clock,
  input logic                   rst_n,
  multi_line_shift_ram_if.slave bus
);

  localparam int CNT_W  = $clog2(TAP_NUM*MAX_LENGTH+1);
  localparam int RAM_AW = (MAX_LENGTH > 1) ? $clog2(MAX_LENGTH) : 1;
  localparam int OUT_W  = TAP_NUM*INPUT_WIDTH;

  function automatic logic [ADDR_WIDTH-1:0] clamp_len(input logic [ADDR_WIDTH-1:0] len);
    if (len == '0 || len > ADDR_WIDTH'(MAX_LENGTH)) return ADDR_WIDTH'(MAX_LENGTH);
    return len;
  endfunction

  // True once at least `lines` full lines have been accepted since the last clear.
  function automatic logic filled(input logic [CNT_W-1:0] cnt, input logic [ADDR_WIDTH-1:0] len,
                                  input int lines);
    return 32'(cnt) >= 32'(lines) * 32'(len);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic [ADDR_WIDTH-1:0] len);
    if (filled(cnt, len, TAP_NUM)) return cnt;
    return cnt + CNT_W'(1);
  endfunction

  logic [INPUT_WIDTH-1:0] mem_q [TAP_NUM][MAX_LENGTH];
  logic [INPUT_WIDTH-1:0] rd    [TAP_NUM];

  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [OUT_W-1:0]      tap_q, tap_d;
  logic                  en_q,  en_d;
  logic                  vld_q, vld_d;
  logic                  accept;
  logic [RAM_AW-1:0]     addr;

  assign accept = bus.clken && !bus.sync_clr;
  assign addr   = RAM_AW'(ptr_q);

  always_comb begin
    for (int k = 0; k < TAP_NUM; k++) rd[k] = mem_q[k][addr];
  end

  always_comb begin
    len_d = len_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    tap_d = tap_q;
    en_d  = 1'b0;
    vld_d = vld_q;
    if (bus.sync_clr) begin
      len_d = clamp_len(bus.line_len);
      ptr_d = '0;
      cnt_d = '0;
      tap_d = '0;
      vld_d = 1'b0;
    end else if (bus.clken) begin
      ptr_d = (ptr_q == len_q - ADDR_WIDTH'(1)) ? '0 : ptr_q + ADDR_WIDTH'(1);
      cnt_d = sat_inc(cnt_q, len_q);
      en_d  = 1'b1;
      for (int k = 0; k < TAP_NUM; k++)
        tap_d[k*INPUT_WIDTH +: INPUT_WIDTH] = filled(cnt_q, len_q, k+1) ? rd[k] : '0;
      if (filled(cnt_q, len_q, TAP_NUM)) vld_d = 1'b1;
    end
  end

  // RAM stage: read-before-write shifts each column one bank deeper per accept.
  always_ff @(posedge clock) begin
    if (accept) begin
      mem_q[0][addr] <= bus.shiftin;
      for (int k = 1; k < TAP_NUM; k++) mem_q[k][addr] <= rd[k-1];
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= ADDR_WIDTH'(MAX_LENGTH);
      ptr_q <= '0;
      cnt_q <= '0;
      tap_q <= '0;
      en_q  <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      len_q <= len_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      tap_q <= tap_d;
      en_q  <= en_d;
      vld_q <= vld_d;
    end
  end

`ifdef MULTI_LINE_SHIFT_RAM_OUTREG_EN
  logic [OUT_W-1:0] tap_p1_q;
  logic             en_p1_q;
  logic             vld_p1_q;

  // Output stage: free-running copy, so a clear reaches the pins one cycle later.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      tap_p1_q <= '0;
      en_p1_q  <= 1'b0;
      vld_p1_q <= 1'b0;
    end else begin
      tap_p1_q <= tap_q;
      en_p1_q  <= en_q;
      vld_p1_q <= vld_q;
    end
  end

  assign bus.shiftout    = tap_p1_q;
  assign bus.shiftout_en = en_p1_q;
  assign bus.taps_valid  = vld_p1_q;
`else
  assign bus.shiftout    = tap_q;
  assign bus.shiftout_en = en_q;
  assign bus.taps_valid  = vld_q;
`endif

endmodule

// File: tb/tb_multi_line_shift_ram.sv
// Directed self-checking bench for multi_line_shift_ram (TAP_NUM=2, 8-bit, MAX_LENGTH=640).
module tb_multi_line_shift_ram;
`ifdef MULTI_LINE_SHIFT_RAM_OUTREG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total = 0;

  always #5 clk = ~clk;

  multi_line_shift_ram_if #(.INPUT_WIDTH(8), .TAP_NUM(2), .ADDR_WIDTH(16)) bus ();

  multi_line_shift_ram #(
    .INPUT_WIDTH(8), .MAX_LENGTH(640), .TAP_NUM(2), .ADDR_WIDTH(16)
  ) dut (
    .clock(clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input int t0, input int t1, input int en, input int v);
    chk({tag, ".tap0"}, 32'(bus.shiftout[7:0]), 32'(t0));
    chk({tag, ".tap1"}, 32'(bus.shiftout[15:8]), 32'(t1));
    chk({tag, ".en"}, 32'(bus.shiftout_en), 32'(en));
    chk({tag, ".valid"}, 32'(bus.taps_valid), 32'(v));
  endtask

  // One clock with the given inputs; outputs are observed #1 after the edge that
  // makes them visible (one extra idle edge when the output register is built in).
  task automatic cyc(input logic ce, input logic clr, input logic [15:0] ll, input logic [7:0] d);
    bus.clken = ce; bus.sync_clr = clr; bus.line_len = ll; bus.shiftin = d;
    @(posedge clk); #1;
    bus.clken = 1'b0; bus.sync_clr = 1'b0;
    repeat (LAT) begin @(posedge clk); #1; end
  endtask

  initial begin
    bus.clken = 1'b0; bus.sync_clr = 1'b0; bus.line_len = '0; bus.shiftin = '0;

    #2;
    chk_all("reset", 0, 0, 0, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill and tap alignment, L=4, samples 1..12.
    cyc(1'b1, 1'b1, 16'd4, 8'd77);
    chk_all("clr4", 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 1'b0, 16'd0, 8'(i + 1));
      chk_all($sformatf("fill[%0d]", i), (i >= 4) ? i - 3 : 0, (i >= 8) ? i - 7 : 0, 1, (i >= 8) ? 1 : 0);
    end
    cyc(1'b0, 1'b0, 16'd9, 8'd200);
    chk_all("idle", 8, 4, 0, 1);

    // Enable gaps: same stream, alternating accept and idle cycles.
    cyc(1'b0, 1'b1, 16'd4, 8'd0);
    chk_all("clr4b", 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, 16'd0, 8'(i + 1));
      chk_all($sformatf("gap_acc[%0d]", i), (i >= 4) ? i - 3 : 0, (i >= 8) ? i - 7 : 0, 1, (i >= 8) ? 1 : 0);
      cyc(1'b0, 1'b0, 16'd0, 8'd250);
      chk_all($sformatf("gap_hold[%0d]", i), (i >= 4) ? i - 3 : 0, (i >= 8) ? i - 7 : 0, 0, (i >= 8) ? 1 : 0);
    end

    // Mid-stream clear with a coincident sample that must be dropped.
    cyc(1'b0, 1'b1, 16'd4, 8'd0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 16'd0, 8'(i + 1));
    chk_all("pre_clr", 16, 12, 1, 1);
    cyc(1'b1, 1'b1, 16'd3, 8'd99);
    chk_all("midclr", 0, 0, 0, 0);
    for (int j = 0; j < 8; j++) begin
      cyc(1'b1, 1'b0, 16'd7, 8'(100 + j));
      chk_all($sformatf("l3[%0d]", j), (j >= 3) ? 97 + j : 0, (j >= 6) ? 94 + j : 0, 1, (j >= 6) ? 1 : 0);
    end

    // Length clamping: 0 and 1000 both act as 640.
    for (int t = 0; t < 2; t++) begin
      cyc(1'b0, 1'b1, (t == 0) ? 16'd0 : 16'd1000, 8'd0);
      for (int j = 0; j < 641; j++) begin
        cyc(1'b1, 1'b0, 16'd0, 8'((j % 250) + 1));
        if (j == 639) chk($sformatf("clamp%0d_639.tap0", t), 32'(bus.shiftout[7:0]), 32'd0);
      end
      chk_all($sformatf("clamp%0d_640", t), 1, 0, 1, 0);
    end

    // L=1: tap0 is the previous sample, tap1 the one before.
    cyc(1'b0, 1'b1, 16'd1, 8'd0);
    cyc(1'b1, 1'b0, 16'd0, 8'd5);
    chk_all("l1[0]", 0, 0, 1, 0);
    cyc(1'b1, 1'b0, 16'd0, 8'd6);
    chk_all("l1[1]", 5, 0, 1, 0);
    cyc(1'b1, 1'b0, 16'd0, 8'd7);
    chk_all("l1[2]", 6, 5, 1, 1);
    cyc(1'b1, 1'b0, 16'd0, 8'd8);
    chk_all("l1[3]", 7, 6, 1, 1);

    // Asynchronous reset between edges, then a fresh start at L=640.
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j < 641; j++) begin
      cyc(1'b1, 1'b0, 16'd2, 8'((j % 200) + 3));
      if (j == 0) chk_all("post_rst[0]", 0, 0, 1, 0);
      if (j == 639) chk("post_rst_639.tap0", 32'(bus.shiftout[7:0]), 32'd0);
    end
    chk_all("post_rst_640", 3, 0, 1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
